// File: rtl/pipe_pkg.sv
// Shared types and constants for the 16-bit 5-stage pipeline control blocks.
// Includes the load-use hazard rule used by the hazard sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    typedef logic [3:0] reg_idx_t;

    localparam logic [3:0]  OP_LW    = 4'h8;
    localparam logic [3:0]  OP_HLT   = 4'hF;
    localparam logic [15:0] NOP_INST = 16'hF000;

    // R0 is hard-wired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_f(
        input logic     mem_read,
        input reg_idx_t rd,
        input reg_idx_t rs,
        input logic     uses_rs,
        input reg_idx_t rt,
        input logic     uses_rt
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = uses_rs & (rs == rd);
        rt_hit = uses_rt & (rt == rd);
        return mem_read & (rd != 4'd0) & (rs_hit | rt_hit);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Count register: clear wins, otherwise step unless already all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {W{1'b0}};
        end else if (clr) begin
            q_q <= {W{1'b0}};
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_q <= q_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q_q <= q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / redirect / halt stall sequencer for the 5-stage core.
// Stall outputs are same-cycle combinational; state and counters are registered.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_rd,
    input  logic             redirect,
    input  logic             ex_hlt,
    input  logic             cnt_clr,
    output logic             data_hazard,
    output logic             PC_hazard,
    output logic             pc_hold,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] FCNT_RELOAD = 4'(FLUSH_CYCLES - 32'd1);
    localparam logic       USE_FLUSH   = (FLUSH_CYCLES > 32'd1);

    hz_state_t  state_q;
    logic [3:0] fcnt_q;

    logic load_use_s;
    logic dh_s, pch_s, hold_s, bub_s, halt_s;
    logic stall_inc_s, flush_inc_s;

    assign load_use_s = load_use_f(ex_mem_read, ex_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);

    // Sequencer state; the RUN redirect cycle is itself the first flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_hlt) begin
                        state_q <= HALTED;
                    end else if (redirect && USE_FLUSH) begin
                        state_q <= FLUSH;
                        fcnt_q  <= FCNT_RELOAD;
                    end else begin
                        state_q <= RUN;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        fcnt_q <= FCNT_RELOAD;
                    end else if (fcnt_q <= 4'd1) begin
                        state_q <= RUN;
                        fcnt_q  <= 4'd0;
                    end else begin
                        fcnt_q <= fcnt_q - 4'd1;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                    fcnt_q  <= 4'd0;
                end
            endcase
        end
    end

    // Same-cycle stall decode from current state and EX/ID inputs.
    always_comb begin
        dh_s        = 1'b0;
        pch_s       = 1'b0;
        hold_s      = 1'b0;
        bub_s       = 1'b0;
        halt_s      = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_hlt) begin
                    bub_s = 1'b1;
                end else if (redirect) begin
                    pch_s       = 1'b1;
                    bub_s       = 1'b1;
                    flush_inc_s = 1'b1;
                end else if (load_use_s) begin
                    dh_s        = 1'b1;
                    hold_s      = 1'b1;
                    bub_s       = 1'b1;
                    stall_inc_s = 1'b1;
                end else begin
                    bub_s = 1'b0;
                end
            end
            FLUSH: begin
                pch_s       = 1'b1;
                bub_s       = 1'b1;
                flush_inc_s = redirect;
            end
            HALTED: begin
                dh_s   = 1'b1;
                hold_s = 1'b1;
                bub_s  = 1'b1;
                halt_s = 1'b1;
            end
            default: begin
                bub_s = 1'b0;
            end
        endcase
    end

    // Reset forces every strobe low immediately, independent of the clock.
    assign data_hazard = dh_s   & rst_n;
    assign PC_hazard   = pch_s  & rst_n;
    assign pc_hold     = hold_s & rst_n;
    assign idex_bubble = bub_s  & rst_n;
    assign halted      = halt_s & rst_n;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall_inc_s),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (flush_inc_s),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int FC     = 2;
    localparam int CW     = 16;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [3:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, ex_mem_read, redirect, ex_hlt, cnt_clr;
    logic          data_hazard, PC_hazard, pc_hold, idex_bubble, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: halt flag, remaining wrong-path cycles after the current one, counters.
    bit m_halted;
    int m_left;
    int m_stall;
    int m_flush;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .redirect    (redirect),
        .ex_hlt      (ex_hlt),
        .cnt_clr     (cnt_clr),
        .data_hazard (data_hazard),
        .PC_hazard   (PC_hazard),
        .pc_hold     (pc_hold),
        .idex_bubble (idex_bubble),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0;
        m_left   = 0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    // One clock: drive at negedge, check just after, then advance the model for the posedge.
    task automatic step(input logic [3:0] rs, input logic [3:0] rt, input logic urs, input logic urt,
                        input logic mr, input logic [3:0] rd, input logic rdr, input logic hlt,
                        input logic clr);
        bit e_dh, e_pch, e_hold, e_bub, e_halt, lu, inc_s, inc_f, n_halt;
        int n_left;
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_mem_read = mr; ex_rd = rd; redirect = rdr; ex_hlt = hlt; cnt_clr = clr;
        #1;
        e_dh = 0; e_pch = 0; e_hold = 0; e_bub = 0; e_halt = 0; inc_s = 0; inc_f = 0;
        n_halt = m_halted; n_left = m_left;
        lu = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
        if (!rst_n) begin
            model_reset();
            n_halt = 0; n_left = 0;
        end else if (m_halted) begin
            e_dh = 1; e_hold = 1; e_bub = 1; e_halt = 1;
        end else if (m_left > 0) begin
            e_pch = 1; e_bub = 1;
            if (rdr) begin inc_f = 1; n_left = FC - 1; end
            else n_left = m_left - 1;
        end else if (hlt) begin
            e_bub = 1; n_halt = 1;
        end else if (rdr) begin
            e_pch = 1; e_bub = 1; inc_f = 1; n_left = FC - 1;
        end else if (lu) begin
            e_dh = 1; e_hold = 1; e_bub = 1; inc_s = 1;
        end
        check_val("data_hazard", 32'(data_hazard), 32'(e_dh));
        check_val("PC_hazard",   32'(PC_hazard),   32'(e_pch));
        check_val("pc_hold",     32'(pc_hold),     32'(e_hold));
        check_val("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check_val("halted",      32'(halted),      32'(e_halt));
        check_val("stall_cnt",   32'(stall_cnt),   32'(m_stall));
        check_val("flush_cnt",   32'(flush_cnt),   32'(m_flush));
        if (rst_n) begin
            m_halted = n_halt;
            m_left   = n_left;
            if (clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (inc_s && m_stall < CNTMAX) m_stall++;
                if (inc_f && m_flush < CNTMAX) m_flush++;
            end
        end
    endtask

    task automatic idle();
        step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_step(input bit allow_hlt, input bit allow_clr);
        step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
             allow_hlt && ($urandom_range(0, 150) == 0), allow_clr && ($urandom_range(0, 80) == 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 4'd0; redirect = 1'b0; ex_hlt = 1'b0; cnt_clr = 1'b0;
        model_reset();
        do_reset();
        idle();

        // Load-use on rs, then a quiet cycle.
        step(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle();
        check_val("lu_stall_cnt_1", 32'(stall_cnt), 32'd1);
        // R0 target and a match on rt that is not read.
        step(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(4'd1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        idle();
        check_val("no_stall_cnt", 32'(stall_cnt), 32'd1);

        // Single redirect, then redirect again during the flush.
        step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(); idle(); idle();
        step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(); idle(); idle();
        check_val("flush_cnt_3", 32'(flush_cnt), 32'd3);

        // Redirect together with a load-use: flush path wins.
        step(4'd7, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        idle(); idle();

        // Halt held for 100 cycles under noisy stimulus, then async reset mid-cycle.
        step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) rand_step(1'b1, 1'b0);
        check_val("halt_held", 32'(halted), 32'd1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_dh",     32'(data_hazard), 32'd0);
        check_val("async_rst_hold",   32'(pc_hold),     32'd0);
        check_val("async_rst_bubble", 32'(idex_bubble), 32'd0);
        check_val("async_rst_halted", 32'(halted),      32'd0);
        check_val("async_rst_stall",  32'(stall_cnt),   32'd0);
        model_reset();
        do_reset();

        // Random mix; escape any halt with a reset.
        for (int i = 0; i < 4000; i++) begin
            if (m_halted && $urandom_range(0, 20) == 0) do_reset();
            else rand_step(1'b1, !m_halted);
        end
        do_reset();

        // Saturation of the stall counter, then clear beating an increment.
        for (int i = 0; i < 65540; i++)
            step(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        check_val("stall_sat", 32'(stall_cnt), 32'hFFFF);
        step(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        idle();
        check_val("stall_clr", 32'(stall_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
